// File: rtl/wb_collector.sv
// Writeback collector: buffers per-source results in small FIFOs and drains
// up to NR_WB_PORTS of them per cycle to the scoreboard in round-robin order.
module wb_collector #(
    parameter int NR_SRC        = 5,
    parameter int NR_WB_PORTS   = 2,
    parameter int DEPTH         = 2,
    parameter int TRANS_ID_BITS = 3,
    parameter int XLEN          = 64,
    parameter int EX_W          = 129,
    localparam int SRC_W        = (NR_SRC > 1) ? $clog2(NR_SRC) : 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      flush_i,
    input  logic [NR_SRC-1:0]                         src_valid_i,
    input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]      src_trans_id_i,
    input  logic [NR_SRC-1:0][XLEN-1:0]               src_result_i,
    input  logic [NR_SRC-1:0][EX_W-1:0]               src_ex_i,
    output logic [NR_SRC-1:0]                         src_afull_o,
    output logic [NR_WB_PORTS-1:0]                    wb_valid_o,
    output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [NR_WB_PORTS-1:0][XLEN-1:0]          wb_result_o,
    output logic [NR_WB_PORTS-1:0][EX_W-1:0]          wb_ex_o,
    output logic [NR_WB_PORTS-1:0][SRC_W-1:0]         wb_src_o,
    output logic                                      overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TRANS_ID_BITS + XLEN + EX_W;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(DEPTH - 1);
    localparam logic [SRC_W:0]   NR_SRC_EXT = (SRC_W + 1)'(NR_SRC);
    localparam logic [SRC_W-1:0] LAST_SRC   = SRC_W'(NR_SRC - 1);

    logic [ENT_W-1:0] mem_r  [NR_SRC][DEPTH];
    logic [PTR_W-1:0] wptr_r [NR_SRC];
    logic [PTR_W-1:0] rptr_r [NR_SRC];
    logic [CNT_W-1:0] cnt_r  [NR_SRC];
    logic [SRC_W-1:0] rr_ptr_r;
    logic             overflow_r;

    logic [ENT_W-1:0]  head_s [NR_SRC];
    logic [NR_SRC-1:0] pop_s;
    logic [NR_SRC-1:0] push_ok_s;
    logic [NR_SRC-1:0] ovf_hit_s;
    logic              grant_any_s;
    logic [SRC_W-1:0]  last_src_s;
    logic [SRC_W-1:0]  rr_next_s;
    logic [SRC_W:0]    idx_ext_s;
    logic [SRC_W-1:0]  idx_s;
    int                port_cnt_s;

    // FIFO heads, almost-full flags and push acceptance per source
    always_comb begin
        for (int i = 0; i < NR_SRC; i++) begin
            head_s[i]      = mem_r[i][rptr_r[i]];
            src_afull_o[i] = (cnt_r[i] >= AFULL_CNT);
            // a full FIFO still accepts a push when its head leaves this cycle
            push_ok_s[i]   = src_valid_i[i] && ((cnt_r[i] != FULL_CNT) || pop_s[i]);
            ovf_hit_s[i]   = src_valid_i[i] && (cnt_r[i] == FULL_CNT) && !pop_s[i];
        end
    end

    // Round-robin scan from rr_ptr; successive non-empty sources fill successive ports
    always_comb begin
        pop_s         = '0;
        grant_any_s   = 1'b0;
        last_src_s    = rr_ptr_r;
        wb_valid_o    = '0;
        wb_trans_id_o = '0;
        wb_result_o   = '0;
        wb_ex_o       = '0;
        wb_src_o      = '0;
        port_cnt_s    = 0;
        idx_ext_s     = '0;
        idx_s         = '0;
        for (int j = 0; j < NR_SRC; j++) begin
            idx_ext_s = {1'b0, rr_ptr_r} + (SRC_W + 1)'(j);
            if (idx_ext_s >= NR_SRC_EXT) begin
                idx_ext_s = idx_ext_s - NR_SRC_EXT;
            end else begin
                idx_ext_s = idx_ext_s;
            end
            idx_s = idx_ext_s[SRC_W-1:0];
            if ((cnt_r[idx_s] != '0) && (port_cnt_s < NR_WB_PORTS)) begin
                for (int k = 0; k < NR_WB_PORTS; k++) begin
                    if (k == port_cnt_s) begin
                        wb_valid_o[k] = 1'b1;
                        {wb_trans_id_o[k], wb_result_o[k], wb_ex_o[k]} = head_s[idx_s];
                        wb_src_o[k] = idx_s;
                    end else begin
                        wb_valid_o[k] = wb_valid_o[k];
                    end
                end
                pop_s[idx_s] = 1'b1;
                grant_any_s  = 1'b1;
                last_src_s   = idx_s;
                port_cnt_s   = port_cnt_s + 1;
            end else begin
                port_cnt_s = port_cnt_s;
            end
        end
    end

    // Next round-robin start: one past the last granted source
    always_comb begin
        if (last_src_s == LAST_SRC) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = last_src_s + SRC_W'(1);
        end
    end

    // FIFO storage, pointers, counts, arbiter pointer and sticky overflow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_SRC; i++) begin
                wptr_r[i] <= '0;
                rptr_r[i] <= '0;
                cnt_r[i]  <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    mem_r[i][d] <= '0;
                end
            end
            rr_ptr_r   <= '0;
            overflow_r <= 1'b0;
        end else if (flush_i) begin
            for (int i = 0; i < NR_SRC; i++) begin
                wptr_r[i] <= '0;
                rptr_r[i] <= '0;
                cnt_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NR_SRC; i++) begin
                if (push_ok_s[i]) begin
                    mem_r[i][wptr_r[i]] <= {src_trans_id_i[i], src_result_i[i], src_ex_i[i]};
                    wptr_r[i]           <= wptr_r[i] + PTR_W'(1);
                end else begin
                    wptr_r[i] <= wptr_r[i];
                end
                if (pop_s[i]) begin
                    rptr_r[i] <= rptr_r[i] + PTR_W'(1);
                end else begin
                    rptr_r[i] <= rptr_r[i];
                end
                case ({push_ok_s[i], pop_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
            if (|ovf_hit_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (grant_any_s) begin
                rr_ptr_r <= rr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign overflow_o = overflow_r;

endmodule

// File: tb/tb_wb_collector.sv
// Self-checking bench for wb_collector: per-source scoreboard queues plus a
// reference arbiter predict every writeback, flag and pointer each cycle.
module tb_wb_collector;

    typedef struct packed {
        logic [2:0]   tid;
        logic [63:0]  res;
        logic [128:0] ex;
    } ent_t;

    logic                clk;
    logic                rst;
    logic                flush;
    logic [4:0]          src_valid;
    logic [4:0][2:0]     tid_d;
    logic [4:0][63:0]    res_d;
    logic [4:0][128:0]   ex_d;
    logic [4:0]          src_afull;
    logic [1:0]          wb_valid;
    logic [1:0][2:0]     wb_tid;
    logic [1:0][63:0]    wb_res;
    logic [1:0][128:0]   wb_ex;
    logic [1:0][2:0]     wb_src;
    logic                overflow;

    ent_t sb_q [5][$];
    int   rr_m;
    logic ovf_m;
    int   n_cmp;
    int   n_err;
    int   tally [5];
    logic tally_en;
    logic fix_data;

    wb_collector dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .src_valid_i    (src_valid),
        .src_trans_id_i (tid_d),
        .src_result_i   (res_d),
        .src_ex_i       (ex_d),
        .src_afull_o    (src_afull),
        .wb_valid_o     (wb_valid),
        .wb_trans_id_o  (wb_tid),
        .wb_result_o    (wb_res),
        .wb_ex_o        (wb_ex),
        .wb_src_o       (wb_src),
        .overflow_o     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < 5; i++) begin
            tid_d[i] = 3'($urandom_range(0, 7));
            res_d[i] = {$urandom, $urandom};
            ex_d[i]  = 129'({$urandom, $urandom, $urandom, $urandom, $urandom});
        end
    endtask

    // Check outputs against the model, drive one cycle, then advance the model
    task automatic step(input logic [4:0] v, input logic fl, input logic rs);
        int         gs [2];
        int         np;
        logic [1:0] ev;
        logic [4:0] eaf;
        logic [4:0] popped;
        int         pre_sz [5];
        ent_t       e;
        np = 0;
        for (int j = 0; j < 5; j++) begin
            int s;
            s = (rr_m + j) % 5;
            if (sb_q[s].size() > 0 && np < 2) begin
                gs[np] = s;
                np++;
            end
        end
        ev = 2'b00;
        for (int k = 0; k < np; k++) ev[k] = 1'b1;
        check("wb_valid", 256'(wb_valid), 256'(ev));
        for (int k = 0; k < 2; k++) begin
            if (k < np) begin
                check("wb_src", 256'(wb_src[k]), 256'(gs[k]));
                check("wb_trans_id", 256'(wb_tid[k]), 256'(sb_q[gs[k]][0].tid));
                check("wb_result", 256'(wb_res[k]), 256'(sb_q[gs[k]][0].res));
                check("wb_ex", 256'(wb_ex[k]), 256'(sb_q[gs[k]][0].ex));
            end else begin
                check("idle_port_data", 256'({wb_tid[k], wb_res[k], wb_ex[k], wb_src[k]}), 256'(0));
            end
        end
        if (tally_en) begin
            for (int k = 0; k < 2; k++) begin
                if (wb_valid[k] && wb_src[k] < 3'd5) tally[wb_src[k]]++;
            end
        end
        for (int i = 0; i < 5; i++) eaf[i] = (sb_q[i].size() >= 1);
        check("src_afull", 256'(src_afull), 256'(eaf));
        check("overflow", 256'(overflow), 256'(ovf_m));
        check("rr_ptr", 256'(dut.rr_ptr_r), 256'(rr_m));

        if (!fix_data) rand_data();
        src_valid = v;
        flush     = fl;
        rst       = rs;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) pre_sz[i] = sb_q[i].size();
        if (rs) begin
            for (int i = 0; i < 5; i++) sb_q[i].delete();
            rr_m  = 0;
            ovf_m = 1'b0;
        end else if (fl) begin
            for (int i = 0; i < 5; i++) sb_q[i].delete();
        end else begin
            popped = 5'b0;
            for (int k = 0; k < np; k++) begin
                void'(sb_q[gs[k]].pop_front());
                popped[gs[k]] = 1'b1;
            end
            if (np > 0) rr_m = (gs[np-1] + 1) % 5;
            for (int i = 0; i < 5; i++) begin
                if (v[i]) begin
                    if (pre_sz[i] == 2 && !popped[i]) begin
                        ovf_m = 1'b1;
                    end else begin
                        e.tid = tid_d[i];
                        e.res = res_d[i];
                        e.ex  = ex_d[i];
                        sb_q[i].push_back(e);
                    end
                end
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rr_m      = 0;
        ovf_m     = 1'b0;
        tally_en  = 1'b0;
        fix_data  = 1'b0;
        for (int s = 0; s < 5; s++) tally[s] = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        src_valid = 5'b0;
        rand_data();
        repeat (2) @(posedge clk);
        #1;

        // single source: FLU id 3 / 0xDEAD
        step(5'b00000, 1'b0, 1'b0);
        rand_data();
        tid_d[0] = 3'd3;
        res_d[0] = 64'hDEAD;
        fix_data = 1'b1;
        step(5'b00001, 1'b0, 1'b0);
        fix_data = 1'b0;
        check("single_valid", 256'(wb_valid), 256'(2'b01));
        check("single_tid", 256'(wb_tid[0]), 256'(3'd3));
        check("single_result", 256'(wb_res[0]), 256'(64'hDEAD));
        check("single_src", 256'(wb_src[0]), 256'(3'd0));
        step(5'b00000, 1'b0, 1'b0);
        check("single_drained", 256'(wb_valid), 256'(2'b00));

        // multiple sources 0,1,3 from rr_ptr 0
        step(5'b00000, 1'b0, 1'b1);
        step(5'b01011, 1'b0, 1'b0);
        check("multi_srcs", 256'({wb_src[1], wb_src[0]}), 256'({3'd1, 3'd0}));
        step(5'b00000, 1'b0, 1'b0);
        check("multi_third", 256'({wb_valid, wb_src[0]}), 256'({2'b01, 3'd3}));
        step(5'b00000, 1'b0, 1'b0);
        check("multi_rr", 256'(dut.rr_ptr_r), 256'(3'd4));

        // fairness: all sources kept non-empty for 10 cycles
        step(5'b00000, 1'b0, 1'b1);
        step(5'b11111, 1'b0, 1'b0);
        tally_en = 1'b1;
        for (int c = 0; c < 10; c++) step(5'b11111, 1'b0, 1'b0);
        tally_en = 1'b0;
        for (int s = 0; s < 5; s++) check("fair_cnt", 256'(tally[s]), 256'(4));
        for (int c = 0; c < 4; c++) step(5'b00000, 1'b0, 1'b0);

        // overflow: source 2 pushed 4 cycles while everyone competes
        step(5'b00000, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) step(5'b11111, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step(5'b11011, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) step(5'b00000, 1'b0, 1'b0);
        check("ovf_sticky", 256'(overflow), 256'(1'b1));

        // flush with buffered entries and a simultaneous push on source 4
        step(5'b00000, 1'b0, 1'b1);
        step(5'b00011, 1'b0, 1'b0);
        step(5'b00011, 1'b0, 1'b0);
        step(5'b10000, 1'b1, 1'b0);
        check("flush_valid", 256'(wb_valid), 256'(2'b00));
        check("flush_afull", 256'(src_afull), 256'(5'b0));
        step(5'b00000, 1'b0, 1'b0);

        // reset mid-stream with entries buffered
        step(5'b10101, 1'b0, 1'b0);
        step(5'b00000, 1'b0, 1'b1);
        check("rst_valid", 256'(wb_valid), 256'(2'b00));
        check("rst_rr", 256'(dut.rr_ptr_r), 256'(3'd0));
        check("rst_ovf", 256'(overflow), 256'(1'b0));

        // random traffic with occasional flush and reset
        for (int c = 0; c < 120; c++) begin
            step(5'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
        end
        for (int c = 0; c < 6; c++) step(5'b00000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
